multi_bit_sync_filter: RTL

- Parametrised successor to the single-bit synchronizer: WIDTH independent channels, each with a metastability chain, a glitch filter, and registered edge-detect pulses.
- Sits at the asynchronous pin boundary of the UART, e.g. RX, CTS, or mode straps, ahead of the receiver FSM.
- Filtering is gated by an optional sample strobe, so it can run at the UART oversample rate or at full clock rate.
- The reset value is parametrised, so idle-high lines such as RX do not produce a spurious falling edge after reset.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_filter_channel.sv | 81 ++++++++
 rtl/multi_bit_sync_filter.sv | 37 +++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART block family.
package uart_pkg;

  // Default depth of an asynchronous-input synchronizer chain.
  localparam int SYNC_STAGES_DEFAULT = 3;

  // Width of a counter that must reach len-1. A 1-bit counter is the
  // minimum so that len = 1 still yields a legal vector.
  function automatic int cnt_width(input int len);
    int w;
    w = $clog2(len);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_filter_channel.sv
// One channel: metastability chain, run-length glitch filter and
// registered rise/fall pulses aligned with the filtered level change.
module sync_filter_channel
  import uart_pkg::*;
#(
  parameter int   NUM_STAGES = SYNC_STAGES_DEFAULT,
  parameter int   FILTER_LEN = 4,
  parameter logic RESET_BIT  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic data_in,
  output logic data_out,
  output logic rise,
  output logic fall
);

  localparam int            CW      = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [NUM_STAGES-1:0] chain_reg;
  logic                  sync_bit;
  logic [CW-1:0]         count_reg, count_next;
  logic                  out_reg, out_next;
  logic                  rise_reg, rise_next;
  logic                  fall_reg, fall_next;

  // Only the oldest stage is used; earlier stages may be metastable.
  assign sync_bit = chain_reg[NUM_STAGES-1];

  // Synchronizer chain shifts every cycle, independent of the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_reg <= {NUM_STAGES{RESET_BIT}};
    end else begin
      chain_reg <= {chain_reg[NUM_STAGES-2:0], data_in};
    end
  end

  // Filter decision: count consecutive disagreeing samples, commit on the
  // FILTER_LEN-th one, and raise the matching edge pulse on that same edge.
  always_comb begin
    count_next = count_reg;
    out_next   = out_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if (sample_en) begin
      if (sync_bit == out_reg) begin
        count_next = '0;
      end else if (count_reg == CNT_MAX) begin
        out_next   = sync_bit;
        count_next = '0;
        rise_next  = sync_bit;
        fall_next  = ~sync_bit;
      end else begin
        count_next = count_reg + CW'(1);
      end
    end
  end

  // Filter state and pulse registers; reset drops any partial run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
      out_reg   <= RESET_BIT;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      out_reg   <= out_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  assign data_out = out_reg;
  assign rise     = rise_reg;
  assign fall     = fall_reg;

endmodule

// File: rtl/multi_bit_sync_filter.sv
// WIDTH independent synchronize-and-filter channels for asynchronous UART
// pins and straps; each bit carries its own reset/idle level.
module multi_bit_sync_filter
  import uart_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter int               NUM_STAGES = SYNC_STAGES_DEFAULT,
  parameter int               FILTER_LEN = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // One self-contained channel per bit; no state is shared between bits.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    sync_filter_channel #(
      .NUM_STAGES (NUM_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RESET_BIT  (RESET_VAL[gi])
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .data_in   (data_in[gi]),
      .data_out  (data_out[gi]),
      .rise      (rise[gi]),
      .fall      (fall[gi])
    );
  end

endmodule
